fsma_chan_arb: RTL and testbench

//  Packet-level round-robin arbiter sharing one head/data/tail/valid channel among
//  NUM_REQ packet sources. Grant locks at a head beat and releases after the tail

---
 rtl/fsma_chan_arb_pkg.sv | 25 ++
 rtl/fsma_chan_arb_if.sv | 24 ++
 rtl/fsma_rr_pick.sv | 31 +++
 rtl/fsma_chan_arb.sv | 124 ++++++++++++
 tb/tb_fsma_chan_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsma_chan_arb_pkg.sv
// Shared types and sizing helpers for the packet-level channel arbiter.
// The beat-counter helper matters only when FSMA_ARB_WATCHDOG_EN is defined.
package fsma_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PKT  = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF     = 4;
    localparam int PKT_MAX_LEN_DEF = 16;

    // Requester index width; kept at least 1 bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(NUM_REQ_DEF);

    // Beat counter width, able to hold the value max_len itself.
    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/fsma_chan_arb_if.sv
// Source-side and channel-side beat handshakes of the packet arbiter.
// A beat moves on a lane in any cycle where that lane's valid and ready are both 1.
interface fsma_chan_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_head;
    logic [NUM_REQ-1:0] req_tail;
    logic [NUM_REQ-1:0] req_ready;
    logic               out_valid;
    logic               out_head;
    logic               out_tail;
    logic               out_ready;

    modport master (
        output req_valid, req_head, req_tail, out_ready,
        input  req_ready, out_valid, out_head, out_tail
    );

    modport slave (
        input  req_valid, req_head, req_tail, out_ready,
        output req_ready, out_valid, out_head, out_tail
    );
endinterface

// File: rtl/fsma_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module fsma_rr_pick
    import fsma_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest candidate wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/fsma_chan_arb.sv
// Packet-level round-robin arbiter: the grant locks on a head beat and releases after the tail.
// Define FSMA_ARB_WATCHDOG_EN to force a tail and pulse err_len after PKT_MAX_LEN beats.
module fsma_chan_arb
    import fsma_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int PKT_MAX_LEN = 16,
    localparam int GID_W       = id_w(NUM_REQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    fsma_chan_arb_if.slave    bus,
    output logic [GID_W-1:0]  grant_id,
    output logic              busy,
    output logic              err_len,
    output arb_state_t        o_state_dbg,
    output logic [GID_W-1:0]  o_ptr_dbg
);

    arb_state_t       r_state, w_state_nxt;
    logic [GID_W-1:0] r_grant, w_grant_nxt;
    logic [GID_W-1:0] r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_cands;
    logic             w_found;
    logic [GID_W-1:0] w_pick;
    logic             w_xfer;
    logic             w_wd_hit;

    assign w_cands = bus.req_valid & bus.req_head;

    fsma_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (GID_W)
    ) u_pick (
        .req   (w_cands),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

`ifdef FSMA_ARB_WATCHDOG_EN
    localparam int CNT_W = cnt_w(PKT_MAX_LEN);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    // The beat that would be number PKT_MAX_LEN is the one that closes the packet.
    assign w_wd_hit = (r_state == ARB_PKT) && bus.req_valid[r_grant]
                    && (r_cnt == CNT_W'(PKT_MAX_LEN - 1));
    assign err_len  = w_xfer & w_wd_hit & ~bus.req_tail[r_grant];

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ARB_IDLE && w_found) begin
            w_cnt_nxt = '0;
        end else if (w_xfer && r_cnt != CNT_W'(PKT_MAX_LEN)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_nxt;
    end
`else
    logic w_unused_len;
    assign w_unused_len = (PKT_MAX_LEN > 0);
    assign w_wd_hit     = 1'b0;
    assign err_len      = 1'b0;
`endif

    // Channel mux: only the owner is visible downstream, and only it sees ready.
    always_comb begin
        bus.req_ready = '0;
        bus.out_valid = 1'b0;
        bus.out_head  = 1'b0;
        bus.out_tail  = 1'b0;
        if (r_state == ARB_PKT) begin
            bus.out_valid          = bus.req_valid[r_grant];
            bus.out_head           = bus.req_head[r_grant];
            bus.out_tail           = bus.req_tail[r_grant] | w_wd_hit;
            bus.req_ready[r_grant] = bus.out_ready;
        end
    end

    assign w_xfer = bus.out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_PKT;
                    w_grant_nxt = w_pick;
                end
            end
            ARB_PKT: begin
                if (w_xfer && bus.out_tail) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = (r_grant == GID_W'(NUM_REQ - 1)) ? '0 : r_grant + GID_W'(1);
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign busy        = (r_state == ARB_PKT);
    assign grant_id    = busy ? r_grant : '0;
    assign o_state_dbg = r_state;
    assign o_ptr_dbg   = r_ptr;

endmodule

// File: tb/tb_fsma_chan_arb.sv
// Directed scenarios plus randomized traffic for fsma_chan_arb against a packet-queue model.
module tb_fsma_chan_arb;
    import fsma_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXL = 4;
    localparam int GW   = 2;
`ifdef FSMA_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fsma_chan_arb_if #(.NUM_REQ(N)) bus();
    logic [GW-1:0] grant_id;
    logic [GW-1:0] ptr_dbg;
    logic          busy;
    logic          err_len;
    arb_state_t    state_dbg;

    fsma_chan_arb #(.NUM_REQ(N), .PKT_MAX_LEN(MAXL)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_len     (err_len),
        .o_state_dbg (state_dbg),
        .o_ptr_dbg   (ptr_dbg)
    );

    // ---------------- model and scoreboard state ----------------
    logic [1:0]    src_q [N][$];   // per-source beats, {head, tail}
    logic [GW-1:0] exp_q[$];       // expected grant order
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    int            m_beats = 0;

    int            checks   = 0;
    int            failures = 0;
    int            tick_no  = 0;
    int            dut_beats = 0;
    int            dut_errs  = 0;
    logic [GW-1:0] dut_grants[$];
    logic [GW-1:0] dut_rel_ptr[$];
    int            grant_ticks[$];
    logic          prev_busy = 1'b0;
    int            vld_pct = 100;
    int            rdy_pct = 100;

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_pkt(input int s, input int len);
        for (int i = 0; i < len; i++) src_q[s].push_back({i == 0, i == len - 1});
    endtask

    task automatic push_beat(input int s, input logic h, input logic t);
        src_q[s].push_back({h, t});
    endtask

    task automatic drive();
        logic [N-1:0] v, h, t;
        v = '0; h = '0; t = '0;
        for (int s = 0; s < N; s++) begin
            if (src_q[s].size() > 0 && $urandom_range(99) < vld_pct) begin
                v[s] = 1'b1;
                h[s] = src_q[s][0][1];
                t[s] = src_q[s][0][0];
            end
        end
        bus.req_valid = v;
        bus.req_head  = h;
        bus.req_tail  = t;
        bus.out_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic clear_logs();
        dut_grants.delete();
        dut_rel_ptr.delete();
        grant_ticks.delete();
        dut_beats = 0;
        dut_errs  = 0;
        m_beats   = 0;
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        prev_busy = 1'b0;
        exp_q.delete();
        for (int s = 0; s < N; s++) src_q[s].delete();
    endtask

    // Compare the channel against what the owner currently presents.
    task automatic check_outs();
        logic [N-1:0] e_rdy;
        logic e_v, e_h, e_t, e_err, forced;
        int   o;
        o = m_owner;
        e_rdy = '0; e_v = 1'b0; e_h = 1'b0; e_t = 1'b0; e_err = 1'b0;
        if (o >= 0) begin
            e_v    = bit_at(bus.req_valid, o);
            e_h    = bit_at(bus.req_head, o);
            forced = WD && (m_cnt == MAXL - 1) && e_v;
            e_t    = bit_at(bus.req_tail, o) | forced;
            e_rdy  = bus.out_ready ? (N'(1) << o) : '0;
            e_err  = forced && bus.out_ready && !bit_at(bus.req_tail, o);
        end
        chk("out_valid", bus.out_valid, e_v);
        if (e_v) begin
            chk("out_head", bus.out_head, e_h);
            chk("out_tail", bus.out_tail, e_t);
        end
        chk("req_ready", bus.req_ready, e_rdy);
        chk("busy", busy, (o >= 0));
        chk("grant_id", grant_id, (o >= 0) ? o : 0);
        chk("ptr", ptr_dbg, m_ptr);
        chk("err_len", err_len, e_err);
        chk("state", state_dbg, (o >= 0) ? ARB_PKT : ARB_IDLE);
        if (busy && !prev_busy) begin
            dut_grants.push_back(grant_id);
            grant_ticks.push_back(tick_no);
            if (exp_q.size() > 0) chk("grant_order", grant_id, exp_q.pop_front());
        end
        if (!busy && prev_busy) dut_rel_ptr.push_back(ptr_dbg);
        prev_busy = busy;
        if (bus.out_valid && bus.out_ready) dut_beats++;
        if (err_len) dut_errs++;
    endtask

    // Advance the packet-level model by one clock edge.
    task automatic model_step();
        logic [1:0] b, b2;
        logic forced;
        int   o, c;
        o = m_owner;
        if (o < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (bit_at(bus.req_valid, c) && bit_at(bus.req_head, c)) begin
                    m_owner = c;
                    m_cnt   = 0;
                    exp_q.push_back(GW'(c));
                    break;
                end
            end
        end else if (bit_at(bus.req_valid, o) && bus.out_ready) begin
            b      = src_q[o].pop_front();
            forced = WD && (m_cnt == MAXL - 1);
            m_beats++;
            if (m_cnt < MAXL) m_cnt++;
            if (b[0] || forced) begin
                if (!b[0]) begin
                    while (src_q[o].size() > 0) begin
                        b2 = src_q[o].pop_front();
                        if (b2[0]) break;
                    end
                end
                m_ptr   = (o + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        drive();
        #2;
        check_outs();
        @(posedge clock);
        model_step();
        tick_no++;
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int b0;
        int pending;
        int guard;
        bus.req_valid = '0;
        bus.req_head  = '0;
        bus.req_tail  = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ptr", ptr_dbg, 0);
        chk("rst_err", err_len, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: single 3-beat packet from source 0
        clear_logs();
        push_pkt(0, 3);
        run(6);
        chk("t1_grants", dut_grants.size(), 1);
        chk("t1_owner", dut_grants[0], 0);
        chk("t1_beats", dut_beats, 3);
        chk("t1_busy_end", busy, 0);
        chk("t1_ptr", ptr_dbg, 1);

        // Pointer wrap 3 -> 0 after a single-beat packet from source 3
        push_pkt(3, 1);
        run(4);
        chk("wrap_ptr", ptr_dbg, 0);

        // 2: sources 1 and 3 contend, pointer at 0
        clear_logs();
        push_pkt(1, 2);
        push_pkt(3, 3);
        run(10);
        chk("t2_grants", dut_grants.size(), 2);
        chk("t2_first", dut_grants[0], 1);
        chk("t2_second", dut_grants[1], 3);
        chk("t2_ptr_mid", dut_rel_ptr[0], 2);
        chk("t2_ptr_end", dut_rel_ptr[1], 0);
        chk("t2_beats", dut_beats, 5);

        // 3: owner stalls 4 cycles while source 2 waits with a head
        clear_logs();
        push_pkt(0, 4);
        push_pkt(2, 2);
        run(2);
        b0 = dut_beats;
        rdy_pct = 0;
        run(4);
        chk("t3_stall_beats", dut_beats, b0);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_owner", grant_id, 0);
        chk("t3_stall_ready", bus.req_ready, 0);
        rdy_pct = 100;
        run(10);
        chk("t3_order0", dut_grants[0], 0);
        chk("t3_order1", dut_grants[1], 2);
        chk("t3_beats", dut_beats, 6);

        // 4: two back-to-back single-beat packets from source 2
        clear_logs();
        push_pkt(2, 1);
        push_pkt(2, 1);
        run(6);
        chk("t4_grants", dut_grants.size(), 2);
        chk("t4_owner_a", dut_grants[0], 2);
        chk("t4_owner_b", dut_grants[1], 2);
        chk("t4_gap", grant_ticks[1] - grant_ticks[0], 2);

        // 5: six beats without a tail, then a tail beat
        clear_logs();
        push_beat(1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) push_beat(1, 1'b0, 1'b0);
        push_beat(1, 1'b0, 1'b1);
        run(14);
        chk("t5_beats", dut_beats, WD ? 4 : 7);
        chk("t5_errs", dut_errs, WD ? 1 : 0);
        chk("t5_busy_end", busy, 0);
        chk("t5_ptr", ptr_dbg, 2);

        // 6: reset mid-packet, then a headless source must not be granted
        push_pkt(0, 4);
        run(3);
        reset_n = 1'b0;
        #2;
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_ready", bus.req_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_ptr", ptr_dbg, 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        clear_logs();
        push_beat(0, 1'b0, 1'b0);
        push_beat(0, 1'b0, 1'b1);
        run(4);
        chk("t6_no_grant", dut_grants.size(), 0);
        src_q[0].delete();
        push_pkt(0, 1);
        run(4);
        chk("t6_regrant", dut_grants.size(), 1);

        // Randomized traffic with gaps and stalls
        clear_logs();
        vld_pct = 70;
        rdy_pct = 70;
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < N; s++)
                if (src_q[s].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(s, $urandom_range(1, 6));
            tick();
        end
        vld_pct = 100;
        rdy_pct = 100;
        guard   = 0;
        pending = 1;
        while (pending != 0 && guard < 400) begin
            tick();
            guard++;
            pending = (m_owner >= 0) ? 1 : 0;
            for (int s = 0; s < N; s++) if (src_q[s].size() > 0) pending = 1;
        end
        run(2);
        chk("rand_drained", pending, 0);
        chk("rand_beats", dut_beats, m_beats);
        chk("rand_busy_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
